func_pipe_sequencer: RTL

FUNC_PIPE_SEQUENCER -- requirements
Module: func_pipe_sequencer

---
 rtl/func_pipe_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/func_pipe_sequencer.sv
// Credit-based sequencer for a fixed-latency x^2*cos(x)+x/2 datapath: tags each
// accepted operand through the pipe and buffers results in a FWFT FIFO.
module func_pipe_sequencer #(
   parameter int LATENCY    = 20,
   parameter int FIFO_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   output logic        pipe_en,
   output logic [31:0] pipe_x,
   input  logic [31:0] pipe_result,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic        busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [LATENCY-1:0] tag_q, tag_d;
   logic [CW-1:0]      inflight_q, inflight_d;
   logic [CW-1:0]      fifo_count_q, fifo_count_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [31:0]        mem_q [FIFO_DEPTH];
   logic [CW:0]        credit_used_s;
   logic               accept_s;
   logic               capture_s;
   logic               push_s;
   logic               pop_s;

   // Credits are taken from registered counts only, so a pop never frees a slot in the same cycle.
   always_comb begin
      credit_used_s = {1'b0, inflight_q} + {1'b0, fifo_count_q};
      s_ready       = reset && !flush && (credit_used_s < DEPTH_C);
      accept_s      = s_valid && s_ready;
      capture_s     = tag_q[LATENCY-1];
      m_valid       = (fifo_count_q != '0);
      push_s        = capture_s && !flush;
      pop_s         = m_valid && m_ready && !flush;
      pipe_x        = s_data;
      pipe_en       = accept_s || (state_q == RUN);
      busy          = (inflight_q != '0) || m_valid;
      if (m_valid) begin
         m_data = mem_q[rd_ptr_q];
      end else begin
         m_data = '0;
      end
   end

   // Tag shift register and in-flight counter.
   always_comb begin
      tag_d      = tag_q;
      inflight_d = inflight_q;
      if (flush) begin
         tag_d      = '0;
         inflight_d = '0;
      end else begin
         tag_d      = {tag_q[LATENCY-2:0], accept_s};
         inflight_d = inflight_q + CW'(accept_s) - CW'(capture_s);
      end
   end

   // FIFO occupancy and pointer next-state.
   always_comb begin
      fifo_count_d = fifo_count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (flush) begin
         fifo_count_d = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
      end else begin
         fifo_count_d = fifo_count_q + CW'(push_s) - CW'(pop_s);
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // RUN holds pipe_en high while anything is in flight; the datapath delay lines ignore enable.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (inflight_d == '0) begin
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         tag_q        <= '0;
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         inflight_q   <= inflight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Result storage; contents are only observable through m_data while m_valid is high.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= pipe_result;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

endmodule
